y86_pipe_stage_reg: RTL and testbench

- Parametrised inter-stage pipeline register for the Y86-64 PIPE datapath. One instance serves any stage boundary (F/D, D/E, E/M, M/W).
- Carries the standard control fields (stat, icode, dstE, dstM) plus a generic payload bus.
- Supports stall (hold), bubble (NOP injection with a cleaned destination), configurable depth of 1..4 register slots, a valid bit per slot, a sticky control-conflict flag and stall/bubble event counters.

---
 rtl/y86_pipe_stage_reg.sv | 131 +++++++++++++
 tb/tb_y86_pipe_stage_reg.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/y86_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// y86_pipe_stage_reg
//
// Inter-stage pipeline register for the Y86-64 PIPE datapath. A single
// parametrised block serves any stage boundary (F/D, D/E, E/M, M/W). It carries
// the control fields (stat, icode, dstE, dstM), an opaque payload bus and a
// per-slot valid bit through DEPTH chained register slots.
//
// Edge behaviour (reset has highest priority):
//   reset           : every slot becomes a NOP, flags and counters clear
//   stall           : all slots hold, stall_cnt increments (bubble is ignored)
//   bubble, !stall  : slot 0 loads a NOP, higher slots shift, bubble_cnt++
//   otherwise       : slot 0 loads the inputs, higher slots shift
//
// Ports:
//   clk, reset                  rising-edge clock, synchronous active-high reset
//   in_stat/icode/dstE/dstM     upstream control fields
//   in_payload, in_valid        upstream opaque payload and valid bit
//   stall, bubble               hazard-unit controls
//   out_*                       contents of the last slot (DEPTH-1)
//   ctl_err                     sticky: stall and bubble were seen together
//   stall_cnt, bubble_cnt       saturating event counters
// -----------------------------------------------------------------------------
module y86_pipe_stage_reg #(
  parameter int              PAYLOAD_W = 129,
  parameter int              DEPTH     = 1,
  parameter logic [3:0]      NOP_ICODE = 4'h1,
  parameter logic [3:0]      RNONE     = 4'hF,
  parameter logic [2:0]      STAT_AOK  = 3'd1,
  parameter int              CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           in_stat,
  input  logic [3:0]           in_icode,
  input  logic [3:0]           in_dstE,
  input  logic [3:0]           in_dstM,
  input  logic [PAYLOAD_W-1:0] in_payload,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 bubble,
  output logic [2:0]           out_stat,
  output logic [3:0]           out_icode,
  output logic [3:0]           out_dstE,
  output logic [3:0]           out_dstM,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic                 out_valid,
  output logic                 ctl_err,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  generate
    if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
      $error("y86_pipe_stage_reg: DEPTH must be in 1..4");
    end
  endgenerate

  typedef struct packed {
    logic [2:0]           stat;
    logic [3:0]           icode;
    logic [3:0]           dst_e;
    logic [3:0]           dst_m;
    logic [PAYLOAD_W-1:0] payload;
    logic                 valid;
  } slot_t;

  // Both destinations are RNONE so a bubbled slot can never write back or
  // match a forwarding comparison downstream.
  localparam slot_t NOP_SLOT = '{
    stat:    STAT_AOK,
    icode:   NOP_ICODE,
    dst_e:   RNONE,
    dst_m:   RNONE,
    payload: '0,
    valid:   1'b0
  };

  slot_t slot_q [DEPTH];
  slot_t in_slot;

  assign in_slot = '{
    stat:    in_stat,
    icode:   in_icode,
    dst_e:   in_dstE,
    dst_m:   in_dstM,
    payload: in_payload,
    valid:   in_valid
  };

  // NOTE: every slot is reset explicitly; these are discrete flops, not a RAM,
  // so clearing them costs nothing and guarantees in-flight work is dropped.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so slot i samples the value
    // slot i-1 held before this edge regardless of statement order.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        slot_q[i] <= NOP_SLOT;
      end
      ctl_err    <= 1'b0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (stall && bubble) begin
        ctl_err <= 1'b1;
      end

      if (stall) begin
        if (stall_cnt != '1) begin
          stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        slot_q[0] <= bubble ? NOP_SLOT : in_slot;
        for (int i = 1; i < DEPTH; i++) begin
          slot_q[i] <= slot_q[i-1];
        end
        if (bubble && bubble_cnt != '1) begin
          bubble_cnt <= bubble_cnt + 1'b1;
        end
      end
    end
  end

  assign out_stat    = slot_q[DEPTH-1].stat;
  assign out_icode   = slot_q[DEPTH-1].icode;
  assign out_dstE    = slot_q[DEPTH-1].dst_e;
  assign out_dstM    = slot_q[DEPTH-1].dst_m;
  assign out_payload = slot_q[DEPTH-1].payload;
  assign out_valid   = slot_q[DEPTH-1].valid;

endmodule

// File: tb/tb_y86_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_y86_pipe_stage_reg
//
// Three instances share one stimulus stream: a DEPTH=1 register, a DEPTH=3
// register and a DEPTH=1 register with 2-bit counters (saturation). Stimulus
// pushes hand-computed expectations, tagged with the cycle they apply to, into
// a queue; a monitor on the falling edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_y86_pipe_stage_reg;

  localparam int PW = 129;

  logic          clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [2:0]    in_stat;
  logic [3:0]    in_icode, in_dste, in_dstm;
  logic [PW-1:0] in_payload;
  logic          in_valid, stall, bubble;

  logic [2:0]    a_stat, b_stat, c_stat;
  logic [3:0]    a_icode, b_icode, c_icode;
  logic [3:0]    a_dste, b_dste, c_dste;
  logic [3:0]    a_dstm, b_dstm, c_dstm;
  logic [PW-1:0] a_payload, b_payload, c_payload;
  logic          a_valid, b_valid, c_valid;
  logic          a_ctl, b_ctl, c_ctl;
  logic [15:0]   a_scnt, a_bcnt, b_scnt, b_bcnt;
  logic [1:0]    c_scnt, c_bcnt;

  y86_pipe_stage_reg #(.DEPTH(1)) dut_a (
    .clk(clk), .reset(reset), .in_stat(in_stat), .in_icode(in_icode),
    .in_dstE(in_dste), .in_dstM(in_dstm), .in_payload(in_payload),
    .in_valid(in_valid), .stall(stall), .bubble(bubble),
    .out_stat(a_stat), .out_icode(a_icode), .out_dstE(a_dste), .out_dstM(a_dstm),
    .out_payload(a_payload), .out_valid(a_valid), .ctl_err(a_ctl),
    .stall_cnt(a_scnt), .bubble_cnt(a_bcnt));

  y86_pipe_stage_reg #(.DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .in_stat(in_stat), .in_icode(in_icode),
    .in_dstE(in_dste), .in_dstM(in_dstm), .in_payload(in_payload),
    .in_valid(in_valid), .stall(stall), .bubble(bubble),
    .out_stat(b_stat), .out_icode(b_icode), .out_dstE(b_dste), .out_dstM(b_dstm),
    .out_payload(b_payload), .out_valid(b_valid), .ctl_err(b_ctl),
    .stall_cnt(b_scnt), .bubble_cnt(b_bcnt));

  y86_pipe_stage_reg #(.DEPTH(1), .CNT_W(2)) dut_c (
    .clk(clk), .reset(reset), .in_stat(in_stat), .in_icode(in_icode),
    .in_dstE(in_dste), .in_dstM(in_dstm), .in_payload(in_payload),
    .in_valid(in_valid), .stall(stall), .bubble(bubble),
    .out_stat(c_stat), .out_icode(c_icode), .out_dstE(c_dste), .out_dstM(c_dstm),
    .out_payload(c_payload), .out_valid(c_valid), .ctl_err(c_ctl),
    .stall_cnt(c_scnt), .bubble_cnt(c_bcnt));

  // kind 0: full check of dut_a, kind 1: full check of dut_b,
  // kind 2: stall_cnt of dut_c only.
  typedef struct {
    int            cyc;
    int            kind;
    string         name;
    logic [2:0]    stat;
    logic [3:0]    icode, dste, dstm;
    logic [PW-1:0] payload;
    logic          valid, ctl;
    logic [15:0]   scnt, bcnt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   tgt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compares every expectation due in the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t        e;
      logic [177:0] act, want;
      e = q.pop_front();
      case (e.kind)
        0: begin
          act  = {a_stat, a_icode, a_dste, a_dstm, a_payload, a_valid, a_ctl, a_scnt, a_bcnt};
          want = {e.stat, e.icode, e.dste, e.dstm, e.payload, e.valid, e.ctl, e.scnt, e.bcnt};
        end
        1: begin
          act  = {b_stat, b_icode, b_dste, b_dstm, b_payload, b_valid, b_ctl, b_scnt, b_bcnt};
          want = {e.stat, e.icode, e.dste, e.dstm, e.payload, e.valid, e.ctl, e.scnt, e.bcnt};
        end
        default: begin
          act  = {162'b0, 14'b0, c_scnt};
          want = {162'b0, e.scnt};
        end
      endcase
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s: checked late at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
      end else if (act !== want) begin
        n_bad++;
        $display("FAIL %s (cycle %0d): got %h, required %h", e.name, cyc, act, want);
      end
    end
  end

  // Drive inputs just after a rising edge; the following edge consumes them.
  task automatic drive(input logic r, input logic st, input logic bb,
                       input logic [2:0] s, input logic [3:0] ic,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [PW-1:0] pl, input logic v);
    @(posedge clk);
    #1;
    reset = r; stall = st; bubble = bb;
    in_stat = s; in_icode = ic; in_dste = de; in_dstm = dm;
    in_payload = pl; in_valid = v;
    tgt = cyc + 1;
  endtask

  task automatic idle(input logic r, input logic st, input logic bb);
    drive(r, st, bb, 3'd1, 4'h1, 4'hF, 4'hF, '0, 1'b0);
  endtask

  task automatic expect_full(input int kind, input string name,
                             input logic [2:0] s, input logic [3:0] ic,
                             input logic [3:0] de, input logic [3:0] dm,
                             input logic [PW-1:0] pl, input logic v,
                             input logic ctl, input logic [15:0] sc,
                             input logic [15:0] bc);
    exp_t e;
    e.cyc = tgt; e.kind = kind; e.name = name;
    e.stat = s; e.icode = ic; e.dste = de; e.dstm = dm;
    e.payload = pl; e.valid = v; e.ctl = ctl; e.scnt = sc; e.bcnt = bc;
    q.push_back(e);
  endtask

  task automatic expect_nop(input int kind, input string name, input logic ctl,
                            input logic [15:0] sc, input logic [15:0] bc);
    expect_full(kind, name, 3'd1, 4'h1, 4'hF, 4'hF, '0, 1'b0, ctl, sc, bc);
  endtask

  localparam logic [PW-1:0] P1 = 129'h1_0000000000000005_0000000000000007;

  initial begin
    reset = 1'b1; stall = 1'b0; bubble = 1'b0;
    in_stat = 3'd1; in_icode = 4'h1; in_dste = 4'hF; in_dstm = 4'hF;
    in_payload = '0; in_valid = 1'b0;

    // ---- DEPTH=1 basics ----
    idle(1'b1, 1'b0, 1'b0);
    expect_nop(0, "a_reset", 1'b0, 16'd0, 16'd0);
    expect_nop(1, "b_reset", 1'b0, 16'd0, 16'd0);

    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h6, 4'h3, 4'hF, P1, 1'b1);
    expect_full(0, "a_load", 3'd1, 4'h6, 4'h3, 4'hF, P1, 1'b1, 1'b0, 16'd0, 16'd0);

    drive(1'b0, 1'b0, 1'b1, 3'd1, 4'h5, 4'h3, 4'h2, P1, 1'b1);
    expect_nop(0, "a_bubble", 1'b0, 16'd0, 16'd1);

    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'hA, 4'h4, 4'h5, 129'h55, 1'b1);
    expect_full(0, "a_load_a", 3'd1, 4'hA, 4'h4, 4'h5, 129'h55, 1'b1, 1'b0, 16'd0, 16'd1);

    for (int k = 1; k <= 3; k++) begin
      drive(1'b0, 1'b1, 1'b0, 3'd2, 4'h7, 4'h6, 4'h6, 129'h77, 1'b1);
      expect_full(0, "a_stall_hold", 3'd1, 4'hA, 4'h4, 4'h5, 129'h55, 1'b1, 1'b0,
                  16'(k), 16'd1);
    end

    drive(1'b0, 1'b1, 1'b1, 3'd2, 4'h7, 4'h6, 4'h6, 129'h77, 1'b1);
    expect_full(0, "a_stall_bubble", 3'd1, 4'hA, 4'h4, 4'h5, 129'h55, 1'b1, 1'b1,
                16'd4, 16'd1);

    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h2, 4'h1, 4'hF, '0, 1'b1);
    expect_full(0, "a_ctl_sticky", 3'd1, 4'h2, 4'h1, 4'hF, '0, 1'b1, 1'b1, 16'd4, 16'd1);

    idle(1'b1, 1'b0, 1'b0);
    expect_nop(0, "a_ctl_clear", 1'b0, 16'd0, 16'd0);
    expect_nop(1, "b_reset2", 1'b0, 16'd0, 16'd0);

    // ---- DEPTH=3 stream with a stall on the fourth edge ----
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h2, 4'h2, 4'hF, 129'h2, 1'b1);
    expect_nop(1, "b_fill1", 1'b0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h3, 4'h3, 4'hF, 129'h3, 1'b1);
    expect_nop(1, "b_fill2", 1'b0, 16'd0, 16'd0);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h4, 4'h4, 4'hF, 129'h4, 1'b1);
    expect_full(1, "b_out2", 3'd1, 4'h2, 4'h2, 4'hF, 129'h2, 1'b1, 1'b0, 16'd0, 16'd0);
    idle(1'b0, 1'b1, 1'b0);
    expect_full(1, "b_stall", 3'd1, 4'h2, 4'h2, 4'hF, 129'h2, 1'b1, 1'b0, 16'd1, 16'd0);
    idle(1'b0, 1'b0, 1'b0);
    expect_full(1, "b_out3", 3'd1, 4'h3, 4'h3, 4'hF, 129'h3, 1'b1, 1'b0, 16'd1, 16'd0);
    idle(1'b0, 1'b0, 1'b0);
    expect_full(1, "b_out4", 3'd1, 4'h4, 4'h4, 4'hF, 129'h4, 1'b1, 1'b0, 16'd1, 16'd0);
    idle(1'b0, 1'b0, 1'b0);
    expect_nop(1, "b_drain", 1'b0, 16'd1, 16'd0);

    // ---- DEPTH=3 full pipe, then reset mid-stream ----
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h5, 4'h5, 4'hF, 129'h5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h6, 4'h6, 4'hF, 129'h6, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 3'd1, 4'h7, 4'h7, 4'hF, 129'h7, 1'b1);
    expect_full(1, "b_full", 3'd1, 4'h5, 4'h5, 4'hF, 129'h5, 1'b1, 1'b0, 16'd1, 16'd0);
    drive(1'b1, 1'b0, 1'b0, 3'd1, 4'h8, 4'h8, 4'hF, 129'h8, 1'b1);
    expect_nop(1, "b_reset_mid", 1'b0, 16'd0, 16'd0);
    idle(1'b0, 1'b0, 1'b0);
    expect_nop(1, "b_after_rst1", 1'b0, 16'd0, 16'd0);
    idle(1'b0, 1'b0, 1'b0);
    expect_nop(1, "b_after_rst2", 1'b0, 16'd0, 16'd0);

    // ---- counter saturation with CNT_W=2 ----
    for (int k = 1; k <= 5; k++) begin
      idle(1'b0, 1'b1, 1'b0);
      expect_full(2, "c_sat", 3'd0, 4'h0, 4'h0, 4'h0, '0, 1'b0, 1'b0,
                  (k > 3) ? 16'd3 : 16'(k), 16'd0);
    end
    expect_nop(0, "a_stall5", 1'b0, 16'd5, 16'd0);

    idle(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations still pending, required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
